// File: rtl/alu_decode_stage.sv
// RV32I decode stage: a single registered slot between fetch and execute that turns an
// instruction word into ALU control, operand selects, a sign-extended immediate and control flags.
module alu_decode_stage #(
  parameter logic [31:0] RESET_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [3:0]  out_alu_ctrl,
  output logic [1:0]  out_sel_a,
  output logic        out_sel_b,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_branch,
  output logic        out_jump,
  output logic        out_illegal
);

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [1:0] SEL_A_PC   = 2'b01;
  localparam logic [1:0] SEL_A_ZERO = 2'b10;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  ctrl;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{instr: RESET_NOP, default: '0};

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic        legal;
  entry_t      dec_d;
  entry_t      entry_d, entry_q;
  logic        valid_d, valid_q;
  logic        accept, consume;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{21{in_instr[31]}}, in_instr[30:20]};
  assign imm_s = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  // Legal shifts always have instr[31]=0, so the shift amount alone is the immediate.
  assign shamt = {27'b0, in_instr[24:20]};

  always_comb begin
    legal       = 1'b1;
    dec_d       = '0;
    dec_d.instr = in_instr;
    dec_d.pc    = in_pc;
    dec_d.rs1   = in_instr[19:15];
    dec_d.rs2   = in_instr[24:20];
    dec_d.rd    = in_instr[11:7];
    dec_d.ctrl  = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec_d.ctrl      = {funct7[5], funct3};
        dec_d.reg_write = 1'b1;
        legal = (funct7 == 7'h00) ||
                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OP_IMM: begin
        dec_d.ctrl      = {1'b0, funct3};
        dec_d.sel_b     = 1'b1;
        dec_d.imm       = imm_i;
        dec_d.reg_write = 1'b1;
        if (funct3 == 3'b001) begin
          dec_d.imm = shamt;
          legal     = (funct7 == 7'h00);
        end else if (funct3 == 3'b101) begin
          dec_d.imm = shamt;
          legal     = (funct7 == 7'h00) || (funct7 == 7'h20);
          if (funct7 == 7'h20) dec_d.ctrl = ALU_SRA;
        end
      end
      OPC_LOAD: begin
        dec_d.sel_b     = 1'b1;
        dec_d.imm       = imm_i;
        dec_d.mem_read  = 1'b1;
        dec_d.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec_d.sel_b     = 1'b1;
        dec_d.imm       = imm_s;
        dec_d.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.imm    = imm_b;
        dec_d.branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec_d.ctrl = ALU_SUB;
          3'b100, 3'b101: dec_d.ctrl = ALU_SLT;
          3'b110, 3'b111: dec_d.ctrl = ALU_SLTU;
          default:        legal      = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_d.sel_a     = SEL_A_ZERO;
        dec_d.sel_b     = 1'b1;
        dec_d.imm       = imm_u;
        dec_d.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d.sel_a     = SEL_A_PC;
        dec_d.sel_b     = 1'b1;
        dec_d.imm       = imm_u;
        dec_d.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec_d.sel_a     = SEL_A_PC;
        dec_d.sel_b     = 1'b1;
        dec_d.imm       = imm_j;
        dec_d.jump      = 1'b1;
        dec_d.reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec_d.sel_b     = 1'b1;
        dec_d.imm       = imm_i;
        dec_d.jump      = 1'b1;
        dec_d.reg_write = 1'b1;
        legal           = (funct3 == 3'b000);
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec_d.ctrl      = ALU_ADD;
      dec_d.sel_a     = '0;
      dec_d.sel_b     = 1'b0;
      dec_d.imm       = '0;
      dec_d.reg_write = 1'b0;
      dec_d.mem_read  = 1'b0;
      dec_d.mem_write = 1'b0;
      dec_d.branch    = 1'b0;
      dec_d.jump      = 1'b0;
      dec_d.illegal   = 1'b1;
    end
  end

  // Handshake: a transfer happens on an edge where valid && ready on that side. in_ready is
  // combinational (slot empty or being drained), so a consume and an accept may share an edge.
  // flush clears the slot and drops any word accepted on the same edge.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = valid_q && out_ready;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      entry_d = dec_d;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= RESET_ENTRY;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_instr     = entry_q.instr;
  assign out_pc        = entry_q.pc;
  assign out_alu_ctrl  = entry_q.ctrl;
  assign out_sel_a     = entry_q.sel_a;
  assign out_sel_b     = entry_q.sel_b;
  assign out_imm       = entry_q.imm;
  assign out_rs1       = entry_q.rs1;
  assign out_rs2       = entry_q.rs2;
  assign out_rd        = entry_q.rd;
  assign out_reg_write = entry_q.reg_write;
  assign out_mem_read  = entry_q.mem_read;
  assign out_mem_write = entry_q.mem_write;
  assign out_branch    = entry_q.branch;
  assign out_jump      = entry_q.jump;
  assign out_illegal   = entry_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed decode table, stall, flush, randomized traffic and
// asynchronous reset, checked against an instruction-level reference decoder.
module tb_alu_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = NOP;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [3:0]  out_alu_ctrl;
  logic [1:0]  out_sel_a;
  logic        out_sel_b;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal;

  always #5 clk = ~clk;

  alu_decode_stage #(.RESET_NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_alu_ctrl(out_alu_ctrl),
    .out_sel_a(out_sel_a), .out_sel_b(out_sel_b), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  ctrl;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jp;
    logic        ill;
  } out_t;

  localparam int W = $bits(out_t);
  localparam out_t RST_E = '{instr: NOP, default: '0};

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  out_t obs_w;

  assign obs_w = '{valid: out_valid, instr: out_instr, pc: out_pc, imm: out_imm,
                   ctrl: out_alu_ctrl, sel_a: out_sel_a, sel_b: out_sel_b,
                   rs1: out_rs1, rs2: out_rs2, rd: out_rd, rw: out_reg_write,
                   mr: out_mem_read, mw: out_mem_write, br: out_branch,
                   jp: out_jump, ill: out_illegal};

  // Instruction-level reference decoder, written from the ISA rules.
  function automatic out_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    out_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] sx, i_imm, s_imm, b_imm, u_imm, j_imm;
    logic ok;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    sx    = w[31] ? 32'hFFFF_FFFF : 32'h0;
    i_imm = 32'($signed(w) >>> 20);
    s_imm = (i_imm & 32'hFFFF_FFE0) | {27'b0, w[11:7]};
    b_imm = (sx & 32'hFFFF_F000) | ({31'b0, w[7]} << 11) | ({26'b0, w[30:25]} << 5)
          | ({28'b0, w[11:8]} << 1);
    u_imm = w & 32'hFFFF_F000;
    j_imm = (sx & 32'hFFF0_0000) | ({24'b0, w[19:12]} << 12) | ({31'b0, w[20]} << 11)
          | ({22'b0, w[30:21]} << 1);
    e = '0;
    e.valid = 1'b1; e.instr = w; e.pc = pc;
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    ok = 1'b1;
    case (op)
      7'h33: begin
        e.rw = 1'b1;
        if (f7 == 7'h00) e.ctrl = {1'b0, f3};
        else if (f7 == 7'h20 && f3 == 3'd0) e.ctrl = 4'h8;
        else if (f7 == 7'h20 && f3 == 3'd5) e.ctrl = 4'hD;
        else ok = 1'b0;
      end
      7'h13: begin
        e.rw = 1'b1; e.sel_b = 1'b1; e.imm = i_imm; e.ctrl = {1'b0, f3};
        if (f3 == 3'd1 || f3 == 3'd5) e.imm = {27'b0, w[24:20]};
        if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
        if (f3 == 3'd5 && f7 == 7'h20) e.ctrl = 4'hD;
        else if (f3 == 3'd5 && f7 != 7'h00) ok = 1'b0;
      end
      7'h03: begin e.sel_b = 1'b1; e.imm = i_imm; e.mr = 1'b1; e.rw = 1'b1; end
      7'h23: begin e.sel_b = 1'b1; e.imm = s_imm; e.mw = 1'b1; end
      7'h63: begin
        e.imm = b_imm; e.br = 1'b1;
        if (f3 == 3'd0 || f3 == 3'd1) e.ctrl = 4'h8;
        else if (f3 == 3'd4 || f3 == 3'd5) e.ctrl = 4'h2;
        else if (f3 == 3'd6 || f3 == 3'd7) e.ctrl = 4'h3;
        else ok = 1'b0;
      end
      7'h37: begin e.sel_a = 2'b10; e.sel_b = 1'b1; e.imm = u_imm; e.rw = 1'b1; end
      7'h17: begin e.sel_a = 2'b01; e.sel_b = 1'b1; e.imm = u_imm; e.rw = 1'b1; end
      7'h6F: begin e.sel_a = 2'b01; e.sel_b = 1'b1; e.imm = j_imm; e.jp = 1'b1; e.rw = 1'b1; end
      7'h67: begin
        e.sel_b = 1'b1; e.imm = i_imm; e.jp = 1'b1; e.rw = 1'b1;
        ok = (f3 == 3'd0);
      end
      7'h0F, 7'h73: ;
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.ctrl = '0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jp = 1'b0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Operand selects and immediate are unspecified for some entry kinds; mask them there.
  function automatic out_t care(input out_t x, input out_t e);
    out_t r;
    r = x;
    if (e.ill || e.instr[6:0] == 7'h0F || e.instr[6:0] == 7'h73) begin
      r.sel_a = '0; r.sel_b = 1'b0;
    end
    if (e.ill) r.imm = '0;
    return r;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h37;  6: w[6:0] = 7'h17;  7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h67;  9: w[6:0] = 7'h0F;  10: w[6:0] = 7'h73;
      default: ;
    endcase
    if ((k == 0 || k == 1) && $urandom_range(0, 2) != 0)
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if (k == 8 && $urandom_range(0, 1) != 0) w[14:12] = 3'b000;
    return w;
  endfunction

  // Driver: called at a falling edge; drives one cycle, samples just after driving.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic ordy, input logic fl, output out_t obs, output logic rdy);
    in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    obs = obs_w;
    rdy = in_ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_update(input logic acc, input logic cons, input logic fl,
                              input logic [31:0] w, input logic [31:0] pc);
    logic [W-1:0] d;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (cons && exp_q.size() != 0) d = exp_q.pop_front();
      if (acc) exp_q.push_back(model_decode(w, pc));
    end
  endtask

  task automatic test_reset();
    out_t obs;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    obs = obs_w;
    checks++;
    if (obs !== RST_E) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", obs, RST_E);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_decode_table();
    logic [31:0] tbl [7] = '{32'h002081B3, 32'h402081B3, 32'h40335293, 32'hFFF00093,
                             32'h0020C463, 32'hFFFFFFFF, 32'h602081B3};
    logic [3:0]  ctrl_lit [7] = '{4'h0, 4'h8, 4'hD, 4'h0, 4'h2, 4'h0, 4'h0};
    logic [31:0] imm_lit [7]  = '{32'h0, 32'h0, 32'h3, 32'hFFFFFFFF, 32'h8, 32'h0, 32'h0};
    logic        ill_lit [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        rw_lit [7]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        br_lit [7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int n = 0;
    for (int i = 0; i <= 7; i++) begin
      out_t obs, e;
      logic rdy, v, exp_v;
      logic [31:0] w, pc;
      v = (i < 7); w = tbl[i % 7]; pc = 32'h100 + 32'(i * 4);
      exp_v = (exp_q.size() != 0);
      step(v, w, pc, 1'b1, 1'b0, obs, rdy);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL table_ready[%0d]: got %b want 1", i, rdy); end
      checks++;
      if (obs.valid !== exp_v) begin
        errors++; $display("FAIL table_valid[%0d]: got %b want %b", i, obs.valid, exp_v);
      end
      if (exp_v) begin
        e = out_t'(exp_q[0]);
        checks++;
        if (care(obs, e) !== care(e, e)) begin
          errors++; $display("FAIL table_entry[%0d]: got %h want %h", n, obs, e);
        end
        checks++;
        if (obs.ctrl !== ctrl_lit[n] || obs.ill !== ill_lit[n] || obs.rw !== rw_lit[n] ||
            obs.br !== br_lit[n]) begin
          errors++; $display("FAIL table_lit[%0d]: got ctrl=%h ill=%b rw=%b br=%b want ctrl=%h ill=%b rw=%b br=%b",
                             n, obs.ctrl, obs.ill, obs.rw, obs.br, ctrl_lit[n], ill_lit[n], rw_lit[n], br_lit[n]);
        end
        if (n >= 2 && n <= 4) begin
          checks++;
          if (obs.imm !== imm_lit[n] || obs.sel_b !== 1'b1 && n != 4) begin
            errors++; $display("FAIL table_imm[%0d]: got imm=%h sel_b=%b want imm=%h", n, obs.imm, obs.sel_b, imm_lit[n]);
          end
        end
        if (n == 0) begin
          checks++;
          if (obs.rd !== 5'd3 || obs.rs1 !== 5'd1 || obs.rs2 !== 5'd2) begin
            errors++; $display("FAIL table_regs: got rd=%0d rs1=%0d rs2=%0d want 3 1 2", obs.rd, obs.rs1, obs.rs2);
          end
        end
        n++;
      end
      model_update(v, exp_v, 1'b0, w, pc);
    end
  endtask

  task automatic test_stall();
    out_t obs, snap, e;
    logic rdy;
    step(1'b1, 32'h0062A423, 32'h300, 1'b0, 1'b0, obs, rdy);
    model_update(1'b1, 1'b0, 1'b0, 32'h0062A423, 32'h300);
    snap = '0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h00C00513, 32'h304, 1'b0, 1'b0, obs, rdy);
      checks++;
      if (rdy !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", k, rdy); end
      e = out_t'(exp_q[0]);
      if (k == 0) snap = obs;
      checks++;
      if (care(obs, e) !== care(e, e) || obs !== snap) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h want %h", k, obs, e);
      end
      model_update(1'b0, 1'b0, 1'b0, 32'h00C00513, 32'h304);
    end
    step(1'b0, NOP, 32'h0, 1'b1, 1'b0, obs, rdy);
    e = out_t'(exp_q[0]);
    checks++;
    if (care(obs, e) !== care(e, e)) begin
      errors++; $display("FAIL stall_release: got %h want %h", obs, e);
    end
    model_update(1'b0, 1'b1, 1'b0, NOP, 32'h0);
  endtask

  task automatic test_flush();
    out_t obs;
    logic rdy;
    step(1'b1, 32'h00500093, 32'h400, 1'b0, 1'b0, obs, rdy);
    model_update(1'b1, 1'b0, 1'b0, 32'h00500093, 32'h400);
    step(1'b1, 32'h00208133, 32'h404, 1'b1, 1'b1, obs, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL flush_ready_full: got %b want 1", rdy); end
    model_update(1'b1, 1'b1, 1'b1, 32'h00208133, 32'h404);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, NOP, 32'h0, 1'b1, 1'b0, obs, rdy);
      checks++;
      if (obs.valid !== 1'b0) begin errors++; $display("FAIL flush_valid[%0d]: got %b want 0", k, obs.valid); end
    end
    step(1'b1, 32'h00308193, 32'h408, 1'b0, 1'b1, obs, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL flush_ready_empty: got %b want 1", rdy); end
    step(1'b0, NOP, 32'h0, 1'b0, 1'b0, obs, rdy);
    checks++;
    if (obs.valid !== 1'b0) begin errors++; $display("FAIL flush_empty_valid: got %b want 0", obs.valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      out_t obs, e;
      logic rdy, v, ordy, fl, exp_v, exp_r;
      logic [31:0] w, pc;
      v = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 19) == 0);
      w = gen_instr(); pc = $urandom & 32'hFFFF_FFFC;
      exp_v = (exp_q.size() != 0);
      exp_r = !exp_v || ordy;
      step(v, w, pc, ordy, fl, obs, rdy);
      checks++;
      if (rdy !== exp_r) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, rdy, exp_r); end
      checks++;
      if (obs.valid !== exp_v) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", c, obs.valid, exp_v); end
      if (exp_v && ordy) begin
        e = out_t'(exp_q[0]);
        checks++;
        if (care(obs, e) !== care(e, e)) begin
          errors++; $display("FAIL rand_entry[%0d]: got %h want %h", c, obs, e);
        end
      end
      model_update(v && exp_r, exp_v && ordy, fl, w, pc);
    end
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    out_t obs;
    logic rdy;
    step(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0, obs, rdy);
    model_update(1'b1, 1'b0, 1'b0, 32'h002081B3, 32'h200);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    obs = obs_w;
    checks++;
    if (obs !== RST_E) begin errors++; $display("FAIL areset_outputs: got %h want %h", obs, RST_E); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_after: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_decode_table();
    test_stall();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
